// File: rtl/dmem_arbiter_if.sv
// Shared bus between the two requesters, dmem_arbiter and data_memory.
// slave: arbiter view. master: requester/memory environment view.
interface dmem_arbiter_if;
    logic        r0_req,       r1_req;
    logic        r0_we,        r1_we;
    logic [63:0] r0_addr,      r1_addr;
    logic [63:0] r0_wdata,     r1_wdata;
    logic        r0_gnt,       r1_gnt;
    logic        r0_rsp_valid, r1_rsp_valid;
    logic [63:0] r0_rdata,     r1_rdata;
    logic        r0_err,       r1_err;
    logic [63:0] mem_address;
    logic [63:0] mem_WriteData;
    logic        mem_MemWrite;
    logic        mem_MemRead;
    logic [63:0] mem_ReadData;

    modport slave (
        input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
        input  mem_ReadData,
        output r0_gnt, r1_gnt, r0_rsp_valid, r1_rsp_valid, r0_rdata, r1_rdata,
        output r0_err, r1_err,
        output mem_address, mem_WriteData, mem_MemWrite, mem_MemRead
    );

    modport master (
        output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr, r0_wdata, r1_wdata,
        output mem_ReadData,
        input  r0_gnt, r1_gnt, r0_rsp_valid, r1_rsp_valid, r0_rdata, r1_rdata,
        input  r0_err, r1_err,
        input  mem_address, mem_WriteData, mem_MemWrite, mem_MemRead
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter/sequencer for the single data_memory port.
// One IDLE->ACCESS pass per transaction; completion pulses the cycle after ACCESS.
// Optional macro DMEM_ARB_FIXED_PRIO_EN: requester 0 always wins ties and no
// round-robin pointer exists; default build is round-robin.
module dmem_arbiter #(
    parameter int unsigned DEPTH = 1024
) (
    input logic          clk,
    input logic          rst,
    dmem_arbiter_if.slave bus
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, state_next;
    logic        any_req;
    logic        pick;
    logic        win;
    logic        cmd_we;
    logic        cmd_ok;
    logic [63:0] cmd_addr;
    logic [63:0] cmd_wdata;
    logic [63:0] sel_addr;

    assign any_req  = bus.r0_req | bus.r1_req;
    assign sel_addr = pick ? bus.r1_addr : bus.r0_addr;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it asks.
    always_comb pick = !bus.r0_req;
`else
    logic last;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        if (bus.r0_req && bus.r1_req) pick = ~last;
        else                          pick = !bus.r0_req;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next state plus grant and memory-port drive (all zero outside ACCESS).
    always_comb begin
        state_next        = state;
        bus.r0_gnt        = 1'b0;
        bus.r1_gnt        = 1'b0;
        bus.mem_address   = '0;
        bus.mem_WriteData = '0;
        bus.mem_MemWrite  = 1'b0;
        bus.mem_MemRead   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_next = ACCESS;
            end
            ACCESS: begin
                state_next        = IDLE;
                bus.r0_gnt        = !win;
                bus.r1_gnt        = win;
                bus.mem_address   = cmd_addr;
                bus.mem_WriteData = cmd_wdata;
                bus.mem_MemWrite  = cmd_ok && cmd_we;
                bus.mem_MemRead   = cmd_ok && !cmd_we;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the winner's command and range check when leaving IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win       <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_ok    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last      <= 1'b1;
`endif
        end else if (state == IDLE && any_req) begin
            win       <= pick;
            cmd_we    <= pick ? bus.r1_we : bus.r0_we;
            cmd_ok    <= sel_addr < 64'(DEPTH);
            cmd_addr  <= sel_addr;
            cmd_wdata <= pick ? bus.r1_wdata : bus.r0_wdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last      <= pick;
`endif
        end
    end

    // Completion: one-cycle response to the ACCESS winner, zero otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.r0_rsp_valid <= 1'b0;
            bus.r1_rsp_valid <= 1'b0;
            bus.r0_rdata     <= '0;
            bus.r1_rdata     <= '0;
            bus.r0_err       <= 1'b0;
            bus.r1_err       <= 1'b0;
        end else begin
            bus.r0_rsp_valid <= 1'b0;
            bus.r1_rsp_valid <= 1'b0;
            bus.r0_rdata     <= '0;
            bus.r1_rdata     <= '0;
            bus.r0_err       <= 1'b0;
            bus.r1_err       <= 1'b0;
            if (state == ACCESS) begin
                if (win) begin
                    bus.r1_rsp_valid <= 1'b1;
                    bus.r1_rdata     <= (cmd_ok && !cmd_we) ? bus.mem_ReadData : '0;
                    bus.r1_err       <= !cmd_ok;
                end else begin
                    bus.r0_rsp_valid <= 1'b1;
                    bus.r0_rdata     <= (cmd_ok && !cmd_we) ? bus.mem_ReadData : '0;
                    bus.r0_err       <= !cmd_ok;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then randomized traffic, checked
// against a transaction-level model (pending commands, winner rule, word array).
module tb_dmem_arbiter;

    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_clr = 1'b1;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Stand-in for data_memory: combinational read, write at the edge.
    // Index wraps on the low bits, so a stray out-of-range strobe corrupts it.
    logic [63:0] mem [0:DEPTH-1];
    assign bus.mem_ReadData = mem[bus.mem_address[9:0]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.mem_MemWrite) begin
            mem[bus.mem_address[9:0]] <= bus.mem_WriteData;
        end
    end

    // Reference model state.
    logic [63:0] ref_mem [0:DEPTH-1];
    logic        pend  [2];
    logic        p_we  [2];
    logic [63:0] p_addr[2];
    logic [63:0] p_wd  [2];
    int          m_last;
    int          total  = 0;
    int          passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive();
        bus.r0_req   = pend[0];
        bus.r0_we    = p_we[0];
        bus.r0_addr  = p_addr[0];
        bus.r0_wdata = p_wd[0];
        bus.r1_req   = pend[1];
        bus.r1_we    = p_we[1];
        bus.r1_addr  = p_addr[1];
        bus.r1_wdata = p_wd[1];
    endtask

    task automatic issue(input int r, input logic we, input logic [63:0] addr, input logic [63:0] wd);
        pend[r]   = 1'b1;
        p_we[r]   = we;
        p_addr[r] = addr;
        p_wd[r]   = wd;
        drive();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_flags"}, 64'({bus.r1_gnt, bus.r0_gnt, bus.r1_rsp_valid, bus.r0_rsp_valid,
                                    bus.r1_err, bus.r0_err, bus.mem_MemWrite, bus.mem_MemRead}), '0);
        check({tag, "_r0_rdata"}, bus.r0_rdata, '0);
        check({tag, "_r1_rdata"}, bus.r1_rdata, '0);
        check({tag, "_mem_address"}, bus.mem_address, '0);
        check({tag, "_mem_wdata"}, bus.mem_WriteData, '0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b1;
        m_last = 1;
    endtask

    // One arbitration: model picks the winner, then ACCESS and completion cycles are checked.
    task automatic round();
        int          w;
        logic        ok;
        logic [63:0] exp_rd;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        w = pend[0] ? 0 : 1;
`else
        if (pend[0] && pend[1]) w = (m_last == 1) ? 0 : 1;
        else                    w = pend[0] ? 0 : 1;
`endif
        m_last = w;
        ok = p_addr[w] < 64'(DEPTH);
        @(posedge clk);
        #1;
        check("gnt", 64'({bus.r1_gnt, bus.r0_gnt}), (w == 0) ? 64'd1 : 64'd2);
        check("strobes", 64'({bus.mem_MemWrite, bus.mem_MemRead}),
              64'({ok && p_we[w], ok && !p_we[w]}));
        check("mem_address", bus.mem_address, p_addr[w]);
        check("mem_wdata", bus.mem_WriteData, p_wd[w]);
        check("rsp_early", 64'({bus.r1_rsp_valid, bus.r0_rsp_valid}), '0);
        exp_rd = '0;
        if (ok) begin
            if (p_we[w]) ref_mem[p_addr[w][9:0]] = p_wd[w];
            else         exp_rd = ref_mem[p_addr[w][9:0]];
        end
        pend[w] = 1'b0;
        drive();
        @(posedge clk);
        #1;
        check("rsp_valid", 64'({bus.r1_rsp_valid, bus.r0_rsp_valid}), (w == 0) ? 64'd1 : 64'd2);
        check("rdata_win", (w == 0) ? bus.r0_rdata : bus.r1_rdata, exp_rd);
        check("err_win", 64'((w == 0) ? bus.r0_err : bus.r1_err), 64'(!ok));
        check("rdata_lose", (w == 0) ? bus.r1_rdata : bus.r0_rdata, '0);
        check("err_lose", 64'((w == 0) ? bus.r1_err : bus.r0_err), '0);
        check("idle_out", 64'({bus.r1_gnt, bus.r0_gnt, bus.mem_MemWrite, bus.mem_MemRead}), '0);
        check("idle_addr", bus.mem_address, '0);
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return {32'($urandom), 32'($urandom)} | 64'h400;
            1:       return $urandom_range(0, 1) ? 64'd1023 : 64'd1024;
            default: return 64'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int r = 0; r < 2; r++) begin
            pend[r] = 1'b0; p_we[r] = 1'b0; p_addr[r] = '0; p_wd[r] = '0;
        end
        drive();
        m_last = 1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mem_clr = 1'b0;
        check_zero("reset_state");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("idle_no_req");

        // Single write then read by r0.
        issue(0, 1'b1, 64'd5, 64'hDEAD_BEEF_0123_4567);
        round();
        issue(0, 1'b0, 64'd5, 64'h0);
        round();

        // Tie from reset with both requests held.
        do_reset();
        issue(0, 1'b1, 64'd20, 64'hA0);
        issue(1, 1'b1, 64'd21, 64'hB1);
        for (int k = 0; k < 4; k++) begin
            round();
            if (!pend[0]) issue(0, 1'b1, 64'(20 + 2 * k), 64'(k + 16'hA00));
            if (!pend[1]) issue(1, 1'b1, 64'(21 + 2 * k), 64'(k + 16'hB00));
        end
        while (pend[0] || pend[1]) round();

        // Range boundary: 1024 and a high-bit address fail, 1023 succeeds.
        issue(1, 1'b1, 64'd1024, 64'hBAD0_BAD0);
        round();
        issue(1, 1'b1, 64'h1_0000_0000, 64'hBAD1_BAD1);
        round();
        issue(1, 1'b1, 64'd1023, 64'h3FF);
        round();
        issue(0, 1'b0, 64'd0, 64'h0);
        round();
        issue(0, 1'b0, 64'd1023, 64'h0);
        round();

        // Interleaved owners.
        issue(0, 1'b1, 64'd3, 64'h11);
        issue(1, 1'b1, 64'd4, 64'h22);
        round();
        round();
        issue(1, 1'b0, 64'd3, 64'h0);
        issue(0, 1'b0, 64'd4, 64'h0);
        round();
        round();

        // Reset during an r0 read's ACCESS cycle.
        issue(0, 1'b0, 64'd3, 64'h0);
        @(posedge clk);
        #1;
        check("rst_mid_gnt", 64'({bus.r1_gnt, bus.r0_gnt}), 64'd1);
        rst = 1'b0;
        pend[0] = 1'b0;
        drive();
        @(posedge clk);
        #1;
        check_zero("rst_mid");
        rst = 1'b1;
        m_last = 1;
        issue(1, 1'b0, 64'd4, 64'h0);
        round();

        // Back-to-back r0 with changing addresses, req held high between.
        issue(0, 1'b1, 64'd10, 64'hAAAA_0001);
        round();
        issue(0, 1'b1, 64'd11, 64'hAAAA_0002);
        round();
        issue(0, 1'b0, 64'd10, 64'h0);
        round();

        // Randomized traffic.
        for (int k = 0; k < 60; k++) begin
            for (int r = 0; r < 2; r++)
                if (!pend[r] && $urandom_range(0, 2) != 0)
                    issue(r, 1'($urandom_range(0, 1)), rand_addr(), {32'($urandom), 32'($urandom)});
            if (!pend[0] && !pend[1])
                issue($urandom_range(0, 1), 1'b0, rand_addr(), '0);
            round();
        end
        while (pend[0] || pend[1]) round();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", passed, total);
        $fatal(1, "watchdog expired");
    end

endmodule
